// File: rtl/lap_timer_pkg.sv
// Shared definitions for the lap timer: state/status encodings, the seconds
// limit and the preset clamp helper.
package lap_timer_pkg;

  localparam logic [1:0] STATUS_IDLE    = 2'b00;
  localparam logic [1:0] STATUS_RUNNING = 2'b01;
  localparam logic [1:0] STATUS_PAUSED  = 2'b10;
  localparam logic [1:0] STATUS_EXPIRED = 2'b11;

  localparam logic [5:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = STATUS_IDLE,
    ST_RUNNING = STATUS_RUNNING,
    ST_PAUSED  = STATUS_PAUSED,
    ST_EXPIRED = STATUS_EXPIRED
  } state_t;

  function automatic logic [5:0] clamp_sec(input logic [5:0] sec);
    return (sec > SEC_MAX) ? SEC_MAX : sec;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Show-ahead FIFO holding captured lap times; a pop on a full FIFO frees the
// slot that a same-cycle push then uses.
module lap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/lap_timer.sv
// Up/down minutes:seconds stopwatch with a prescaled tick, pause/resume that
// keeps the partial second, and a lap capture buffer.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int MIN_W     = 8,
  parameter int LAP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear,
  input  logic                          lap,
  input  logic                          mode,
  input  logic                          load,
  input  logic [MIN_W-1:0]              load_min,
  input  logic [5:0]                    load_sec,
  output logic [MIN_W-1:0]              minutes,
  output logic [5:0]                    seconds,
  output logic [1:0]                    status,
  output logic                          wrap,
  output logic                          expired,
  input  logic                          lap_rd,
  output logic                          lap_valid,
  output logic [MIN_W-1:0]              lap_min,
  output logic [5:0]                    lap_sec,
  output logic [$clog2(LAP_DEPTH):0]    lap_count,
  output logic                          lap_ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [MIN_W-1:0] MIN_MAX    = {MIN_W{1'b1}};
  localparam logic [MIN_W-1:0] MIN_ONE    = MIN_W'(1);

  state_t           r_state;
  logic [MIN_W-1:0] r_min;
  logic [5:0]       r_sec;
  logic [PW-1:0]    r_presc;
  logic             r_mode;
  logic             r_wrap;
  logic             r_expired;
  logic             r_lap_ovf;

  logic [MIN_W-1:0] w_min_nxt;
  logic [5:0]       w_sec_nxt;
  logic             w_wrap_nxt;
  logic             w_hit_zero;
  logic             w_zero;
  logic             w_start_zero;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_fifo_clr;
  logic [MIN_W+5:0] w_lap_dout;

  assign w_zero       = (r_min == '0) && (r_sec == 6'd0);
  assign w_start_zero = load ? ((load_min == '0) && (load_sec == 6'd0)) : w_zero;

  // Next time value for one tick in the latched direction.
  always_comb begin
    w_min_nxt  = r_min;
    w_sec_nxt  = r_sec;
    w_wrap_nxt = 1'b0;
    if (!r_mode) begin
      if (r_sec == SEC_MAX) begin
        w_sec_nxt = 6'd0;
        if (r_min == MIN_MAX) begin
          w_min_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_min_nxt = r_min + MIN_ONE;
        end
      end else begin
        w_sec_nxt = r_sec + 6'd1;
      end
    end else begin
      if (r_sec == 6'd0) begin
        w_sec_nxt = SEC_MAX;
        w_min_nxt = r_min - MIN_ONE;
      end else begin
        w_sec_nxt = r_sec - 6'd1;
      end
    end
  end

  assign w_hit_zero = r_mode && (w_min_nxt == '0) && (w_sec_nxt == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_min     <= '0;
      r_sec     <= 6'd0;
      r_presc   <= '0;
      r_mode    <= 1'b0;
      r_wrap    <= 1'b0;
      r_expired <= 1'b0;
    end else if (clear) begin
      r_state   <= ST_IDLE;
      r_min     <= '0;
      r_sec     <= 6'd0;
      r_presc   <= '0;
      r_wrap    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mode <= mode;
          if (load) begin
            r_min <= load_min;
            r_sec <= clamp_sec(load_sec);
          end
          if (!stop && start) begin
            if (mode && w_start_zero) begin
              r_state   <= ST_EXPIRED;
              r_expired <= 1'b1;
            end else begin
              r_state <= ST_RUNNING;
            end
          end
        end
        ST_RUNNING: begin
          if (stop) begin
            r_state <= ST_PAUSED;
          end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_wrap  <= w_wrap_nxt;
            if (w_hit_zero) begin
              r_state   <= ST_EXPIRED;
              r_expired <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + PRESC_ONE;
          end
        end
        // Prescaler is left untouched so a resume finishes the partial second.
        ST_PAUSED: begin
          if (!stop && start) begin
            if (r_mode && w_zero) begin
              r_state   <= ST_EXPIRED;
              r_expired <= 1'b1;
            end else begin
              r_state <= ST_RUNNING;
            end
          end
        end
        ST_EXPIRED: r_state <= ST_EXPIRED;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_push     = lap && (r_state == ST_RUNNING || r_state == ST_PAUSED);
  assign w_fifo_clr = rst || clear;

  always_ff @(posedge clk) begin
    if (w_fifo_clr) begin
      r_lap_ovf <= 1'b0;
    end else if (w_push && w_full && !lap_rd) begin
      r_lap_ovf <= 1'b1;
    end
  end

  lap_fifo #(
    .WIDTH (MIN_W + 6),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk   (clk),
    .rst   (w_fifo_clr),
    .push  (w_push),
    .pop   (lap_rd),
    .din   ({r_min, r_sec}),
    .dout  (w_lap_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (lap_count)
  );

  assign status    = r_state;
  assign minutes   = r_min;
  assign seconds   = r_sec;
  assign wrap      = r_wrap;
  assign expired   = r_expired;
  assign lap_ovf   = r_lap_ovf;
  assign lap_valid = !w_empty;
  assign lap_min   = w_lap_dout[MIN_W+5:6];
  assign lap_sec   = w_lap_dout[5:0];

endmodule
